// File: rtl/ysyx_23060236_store_buffer_pkg.sv
// Shared types and constants for the LSU store buffer: drain FSM encoding,
// AXI response codes, default device-space base and the buffered entry layout.
package ysyx_23060236_store_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } drain_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  // One posted store as captured from the LSU AW/W channels.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        mmio;
  } sbuf_entry_t;

  // Loads and stores alias when they touch the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/ysyx_23060236_sbuf_fifo.sv
// Entry storage for the store buffer: circular FIFO with natural-wrap
// pointers, an occupancy count, and a per-entry word-address hit vector used
// to detect loads that alias a pending store.
module ysyx_23060236_sbuf_fifo
  import ysyx_23060236_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  sbuf_entry_t              push_entry,
  input  logic                     pop,
  input  logic [31:0]              cmp_addr,
  output sbuf_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         hit
);

  localparam int PW = $clog2(DEPTH);

  sbuf_entry_t        mem_q [DEPTH];
  sbuf_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next pointers, count and valid bits from this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Word-address compare against every valid entry, head included.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid_q[i] & same_word(mem_q[i].addr, cmp_addr);
    end
  end

  // Control state; reset discards every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful under a valid bit.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ysyx_23060236_store_buffer.sv
// Posted-write store buffer between the LSU store channel and the crossbar.
// Stores are acknowledged early and drained in order as single-beat AXI4
// writes; loads aliasing a pending store are held at the AR channel.
// Optional feature: YSYX_23060236_STORE_BUF_MMIO_EN makes stores at or above
// MMIO_BASE non-posted (response forwarded from the crossbar, one at a time).
//
// Handshake rule on every channel: a transfer happens in the cycle where
// valid and ready are both high; a raised valid keeps its payload stable
// until that cycle.
module ysyx_23060236_store_buffer
  import ysyx_23060236_store_buffer_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [2:0]             s_awsize,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [31:0]            s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            m_awaddr,
  output logic [2:0]             m_awsize,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [31:0]            m_wdata,
  output logic [3:0]             m_wstrb,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic [31:0]            m_araddr,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic                   empty,
  output logic                   store_err,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

`ifdef YSYX_23060236_STORE_BUF_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  sbuf_entry_t             push_entry, head;
  logic                    push, pop, push_mmio, hazard;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  count;
  logic [DEPTH-1:0]        hit;
  logic                    aw_hs, w_hs;

  drain_state_e state_q, state_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;
  logic         s_bvalid_q, s_bvalid_d;
  logic [1:0]   s_bresp_q, s_bresp_d;
  logic         mmio_pend_q, mmio_pend_d;
  logic         store_err_q, store_err_d;

  ysyx_23060236_sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .cmp_addr   (s_araddr),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count),
    .hit        (hit)
  );

  // AW and W are taken together; a pending LSU response or device store
  // stalls further pushes.
  assign push_mmio = MMIO_EN & (s_awaddr >= MMIO_BASE);
  assign push      = ~fifo_full & ~s_bvalid_q & ~mmio_pend_q & s_awvalid & s_wvalid;
  assign s_awready = push;
  assign s_wready  = push;
  assign push_entry = '{addr: s_awaddr, size: s_awsize, data: s_wdata,
                        strb: s_wstrb, mmio: push_mmio};

  // Read path: pass-through unless the load word aliases a buffered store.
  assign hazard    = s_arvalid & (|hit);
  assign m_arvalid = s_arvalid & ~hazard;
  assign s_arready = m_arready & ~hazard;
  assign m_araddr  = s_araddr;

  // Head entry feeds the crossbar write channels.
  assign m_awaddr = head.addr;
  assign m_awsize = head.size;
  assign m_wdata  = head.data;
  assign m_wstrb  = head.strb;

  assign s_bvalid  = s_bvalid_q;
  assign s_bresp   = s_bresp_q;
  assign store_err = store_err_q;
  assign empty     = fifo_empty & (state_q == ST_IDLE);
  assign dbg_state = state_q;
  assign dbg_count = count;

  // Drain FSM: issue AW/W for the head, wait for B, then pop.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    pop       = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Going to SEND on a push into an empty buffer saves a cycle.
        if (~fifo_empty | push) state_d = ST_SEND;
      end
      ST_SEND: begin
        m_awvalid = ~aw_done_q;
        m_wvalid  = ~w_done_q;
        aw_hs     = ~aw_done_q & m_awready;
        w_hs      = ~w_done_q & m_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = ST_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LSU response and error tracking: posted stores answer at once, device
  // stores answer with the crossbar's own response when they drain.
  always_comb begin
    s_bvalid_d  = s_bvalid_q;
    s_bresp_d   = s_bresp_q;
    mmio_pend_d = mmio_pend_q;
    store_err_d = store_err_q;
    if (s_bvalid_q & s_bready) s_bvalid_d = 1'b0;
    if (push) begin
      if (push_mmio) begin
        mmio_pend_d = 1'b1;
      end else begin
        s_bvalid_d = 1'b1;
        s_bresp_d  = RESP_OKAY;
      end
    end
    if (pop) begin
      if (head.mmio) begin
        s_bvalid_d  = 1'b1;
        s_bresp_d   = m_bresp;
        mmio_pend_d = 1'b0;
      end else if (m_bresp != RESP_OKAY) begin
        store_err_d = 1'b1;
      end
    end
  end

  // State registers; reset abandons any in-flight crossbar beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= RESP_OKAY;
      mmio_pend_q <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      s_bvalid_q  <= s_bvalid_d;
      s_bresp_q   <= s_bresp_d;
      mmio_pend_q <= mmio_pend_d;
      store_err_q <= store_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_store_buffer.sv
// Self-checking bench for ysyx_23060236_store_buffer (default build).
// A queue model of the posted stores checks every cycle; directed scenarios
// add hand-computed literal checks.
module tb_ysyx_23060236_store_buffer;

  localparam int DEPTH = 4;

  logic        clock, reset;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [2:0]  s_awsize;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awsize;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid, m_arready;
  logic        empty, store_err;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  ysyx_23060236_store_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awsize(s_awsize),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .empty(empty), .store_err(store_err),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // Entry layout: {addr[31:0], size[2:0], data[31:0], strb[3:0]}
  logic [70:0] exp_q[$];
  logic        bv_m, err_m, aw_iss, w_iss;
  int          drained;

  initial begin
    bv_m = 0; err_m = 0; aw_iss = 0; w_iss = 0; drained = 0;
    forever begin
      logic [70:0] e;
      logic        hit_m, exp_push;
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        bv_m = 0; err_m = 0; aw_iss = 0; w_iss = 0;
      end else begin
        hit_m = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
          e = exp_q[i];
          if (e[70:41] == s_araddr[31:2]) hit_m = 1;
        end
        exp_push = (exp_q.size() < DEPTH) && !bv_m && s_awvalid && s_wvalid;

        check("s_awready", {31'd0, s_awready}, {31'd0, exp_push});
        check("s_wready", {31'd0, s_wready}, {31'd0, exp_push});
        check("s_bvalid", {31'd0, s_bvalid}, {31'd0, bv_m});
        if (bv_m) check("s_bresp", {30'd0, s_bresp}, 32'd0);
        check("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
        check("store_err", {31'd0, store_err}, {31'd0, err_m});
        check("m_arvalid", {31'd0, m_arvalid}, {31'd0, s_arvalid && !hit_m});
        check("s_arready", {31'd0, s_arready}, {31'd0, m_arready && !hit_m});
        check("m_araddr", m_araddr, s_araddr);

        if (m_awvalid) begin
          if (exp_q.size() == 0 || aw_iss) check("m_awvalid_spurious", {31'd0, m_awvalid}, 32'd0);
          else begin
            e = exp_q[0];
            check("m_awaddr", m_awaddr, e[70:39]);
            check("m_awsize", {29'd0, m_awsize}, {29'd0, e[38:36]});
          end
        end
        if (m_wvalid) begin
          if (exp_q.size() == 0 || w_iss) check("m_wvalid_spurious", {31'd0, m_wvalid}, 32'd0);
          else begin
            e = exp_q[0];
            check("m_wdata", m_wdata, e[35:4]);
            check("m_wstrb", {28'd0, m_wstrb}, {28'd0, e[3:0]});
          end
        end
        if (m_bready && !(aw_iss && w_iss)) check("m_bready_early", {31'd0, m_bready}, 32'd0);

        if (m_awvalid && m_awready) aw_iss = 1;
        if (m_wvalid && m_wready) w_iss = 1;
        if (m_bvalid && m_bready && exp_q.size() > 0) begin
          if (m_bresp != 2'b00) err_m = 1;
          void'(exp_q.pop_front());
          aw_iss = 0; w_iss = 0;
          drained++;
        end
        if (exp_push) bv_m = 1;
        else if (bv_m && s_bready) bv_m = 0;
        if (exp_push) exp_q.push_back({s_awaddr, s_awsize, s_wdata, s_wstrb});
      end
    end
  end

  // ---------------- crossbar slave responder ----------------
  logic [1:0] slv_resp;

  initial begin
    logic aw_got, w_got, nb;
    aw_got = 0; w_got = 0;
    m_bvalid = 0; m_bresp = 2'b00;
    forever begin
      @(negedge clock);
      nb = m_bvalid;
      if (reset) begin
        aw_got = 0; w_got = 0; nb = 0;
      end else begin
        if (m_awvalid && m_awready) aw_got = 1;
        if (m_wvalid && m_wready) w_got = 1;
        if (m_bvalid && m_bready) nb = 0;
        else if (aw_got && w_got && !m_bvalid) begin
          nb = 1; aw_got = 0; w_got = 0;
        end
      end
      @(posedge clock);
      #1;
      m_bvalid = nb;
      m_bresp  = nb ? slv_resp : 2'b00;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int n;
    step();
    s_awaddr = a; s_awsize = 3'd2; s_wdata = d; s_wstrb = st;
    s_awvalid = 1; s_wvalid = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_awready && n < 60);
    check("store_accept", {31'd0, s_awready}, 32'd1);
    step();
    s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!empty && n < 200);
    check("wait_empty", {31'd0, empty}, 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int d0, n;
    reset = 1;
    s_awaddr = 0; s_awvalid = 0; s_awsize = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
    s_bready = 1; s_araddr = 0; s_arvalid = 0;
    m_awready = 1; m_wready = 1; m_arready = 1; slv_resp = 2'b00;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // Reset state
    @(negedge clock);
    check("rst_s_awready", {31'd0, s_awready}, 32'd0);
    check("rst_s_bvalid", {31'd0, s_bvalid}, 32'd0);
    check("rst_m_awvalid", {31'd0, m_awvalid}, 32'd0);
    check("rst_m_wvalid", {31'd0, m_wvalid}, 32'd0);
    check("rst_m_bready", {31'd0, m_bready}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_store_err", {31'd0, store_err}, 32'd0);
    check("rst_count", {29'd0, dbg_count}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Single store, LSU holds off its response for a while
    step(); s_bready = 0;
    do_store(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clock);
    check("single_bvalid_n1", {31'd0, s_bvalid}, 32'd1);
    check("single_bresp", {30'd0, s_bresp}, 32'd0);
    check("single_awvalid_n1", {31'd0, m_awvalid}, 32'd1);
    check("single_awaddr", m_awaddr, 32'h8000_0010);
    check("single_wdata", m_wdata, 32'hDEAD_BEEF);
    repeat (2) @(negedge clock);
    check("single_bvalid_hold", {31'd0, s_bvalid}, 32'd1);
    step(); s_bready = 1;
    wait_empty();
    check("single_drained", drained, 32'd1);

    // Fill with AW stalled, then release
    d0 = drained;
    step(); m_awready = 0;
    for (int i = 0; i < 4; i++) do_store(32'h8000_0000 + 32'(4 * i), 32'h0000_1000 + 32'(i), 4'hF);
    @(negedge clock);
    check("fill_count", {29'd0, dbg_count}, 32'd4);
    step();
    s_awaddr = 32'h8000_0010; s_wdata = 32'h0000_1004; s_wstrb = 4'hF; s_awsize = 3'd2;
    s_awvalid = 1; s_wvalid = 1;
    @(negedge clock);
    check("fill_full_block", {31'd0, s_awready}, 32'd0);
    step(); m_awready = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_awready && n < 50);
    check("fill_push_after_pop", {31'd0, s_awready}, 32'd1);
    check("fill_one_pop_first", drained - d0, 32'd1);
    step(); s_awvalid = 0; s_wvalid = 0;
    wait_empty();
    check("fill_drained", drained - d0, 32'd5);

    // Load hazard on a pending store
    step(); m_awready = 0;
    do_store(32'h8000_0104, 32'hCAFE_0104, 4'hF);
    step(); s_arvalid = 1; s_araddr = 32'h8000_0106;
    @(negedge clock);
    check("hazard_block_arvalid", {31'd0, m_arvalid}, 32'd0);
    check("hazard_block_arready", {31'd0, s_arready}, 32'd0);
    step(); s_araddr = 32'h8000_0108;
    @(negedge clock);
    check("hazard_pass_arvalid", {31'd0, m_arvalid}, 32'd1);
    check("hazard_pass_arready", {31'd0, s_arready}, 32'd1);
    check("hazard_pass_araddr", m_araddr, 32'h8000_0108);
    step(); s_araddr = 32'h8000_0106; m_awready = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!m_arvalid && n < 50);
    check("hazard_release", {31'd0, m_arvalid}, 32'd1);
    check("hazard_release_empty", {31'd0, empty}, 32'd1);
    step(); s_arvalid = 0;

    // Error response is sticky; later store still drains
    slv_resp = 2'b10;
    do_store(32'h8000_0200, 32'h1111_2222, 4'h3);
    wait_empty();
    check("err_set", {31'd0, store_err}, 32'd1);
    slv_resp = 2'b00;
    d0 = drained;
    do_store(32'h8000_0204, 32'h3333_4444, 4'hC);
    wait_empty();
    check("err_sticky", {31'd0, store_err}, 32'd1);
    check("err_next_drained", drained - d0, 32'd1);

    // Reset in the middle of a drain
    step(); m_awready = 0;
    for (int i = 0; i < 3; i++) do_store(32'h8000_0300 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'hF);
    @(negedge clock);
    check("mid_state_send", {30'd0, dbg_state}, 32'd1);
    check("mid_count", {29'd0, dbg_count}, 32'd3);
    step(); reset = 1;
    step(); reset = 0;
    @(negedge clock);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_awvalid", {31'd0, m_awvalid}, 32'd0);
    check("mid_rst_count", {29'd0, dbg_count}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    check("mid_rst_err", {31'd0, store_err}, 32'd0);
    step(); m_awready = 1;
    d0 = drained;
    do_store(32'h8000_0400, 32'h5555_AAAA, 4'hF);
    wait_empty();
    check("mid_after_drained", drained - d0, 32'd1);

    // Back-to-back burst exercising push and pop in the same cycle
    d0 = drained;
    for (int i = 0; i < 6; i++)
      do_store(32'h8000_0500 + 32'(4 * i), $urandom_range(32'hFFFF_FFFF, 0), 4'(i + 1));
    wait_empty();
    check("burst_drained", drained - d0, 32'd6);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
